// File: rtl/kbd_scan_ctrl_if.sv
// CPU/keyboard-facing bus of the key-event sequencer: receiver bytes in, queued events out.
interface kbd_scan_ctrl_if #(
    parameter int unsigned AW = 3
);
    logic [7:0]  kbd_byte;
    logic        kbd_ready;
    logic        rd_en;
    logic        clr_ovf;
    logic        evt_valid;
    logic [9:0]  evt_data;
    logic [AW:0] fifo_count;
    logic        overflow;
    logic        busy;

    modport master (
        output kbd_byte, kbd_ready, rd_en, clr_ovf,
        input  evt_valid, evt_data, fifo_count, overflow, busy
    );

    modport slave (
        input  kbd_byte, kbd_ready, rd_en, clr_ovf,
        output evt_valid, evt_data, fifo_count, overflow, busy
    );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// PS/2 byte sequencer: folds E0/F0 prefixes into {ext, brk, code} events and queues them.
// Optional build macro KBD_TYPEMATIC_FILTER_EN drops auto-repeated make events.
module kbd_scan_ctrl #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AW          = 3,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input logic           clk,
    input logic           reset,
    kbd_scan_ctrl_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t          state_q, state_nxt;
    logic [TW-1:0]   to_cnt_q, to_cnt_nxt;
    logic            busy_q;

    logic            final_c, push_c, ext_c, brk_c;
    logic [9:0]      evt_c;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CW-1:0]   count_q, count_nxt;
    logic [9:0]      head_q, head_nxt;
    logic            valid_q, ovf_q;
    logic            pop_c, push_ok_c, drop_c;

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic            filt_valid_q;
    logic [8:0]      filt_key_q;
    logic            rpt_c;
`endif

    // State register and prefix timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            to_cnt_q <= to_cnt_nxt;
            busy_q   <= (state_nxt != IDLE);
        end
    end

    // Next state: prefixes accumulate, any other byte completes the event
    always_comb begin
        state_nxt  = state_q;
        to_cnt_nxt = '0;
        if (bus.kbd_ready) begin
            if (bus.kbd_byte == BYTE_E0) begin
                state_nxt = GOT_E0;
            end else if (bus.kbd_byte == BYTE_F0) begin
                case (state_q)
                    IDLE:    state_nxt = GOT_F0;
                    GOT_E0:  state_nxt = GOT_E0F0;
                    default: state_nxt = state_q;
                endcase
            end else begin
                state_nxt = IDLE;
            end
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_nxt = IDLE;
            end else begin
                to_cnt_nxt = to_cnt_q + TW'(1);
            end
        end
    end

    // Event formation and push strobe
    always_comb begin
        ext_c   = (state_q == GOT_E0) || (state_q == GOT_E0F0);
        brk_c   = (state_q == GOT_F0) || (state_q == GOT_E0F0);
        evt_c   = {ext_c, brk_c, bus.kbd_byte};
        final_c = bus.kbd_ready && (bus.kbd_byte != BYTE_E0) && (bus.kbd_byte != BYTE_F0);
`ifdef KBD_TYPEMATIC_FILTER_EN
        rpt_c   = final_c && !brk_c && filt_valid_q && (filt_key_q == {ext_c, bus.kbd_byte});
        push_c  = final_c && !rpt_c;
`else
        push_c  = final_c;
`endif
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    // Last make key seen; a matching break re-arms it so the next press gets through
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_valid_q <= 1'b0;
            filt_key_q   <= '0;
        end else if (final_c) begin
            if (!brk_c) begin
                filt_valid_q <= 1'b1;
                filt_key_q   <= {ext_c, bus.kbd_byte};
            end else if (filt_key_q == {ext_c, bus.kbd_byte}) begin
                filt_valid_q <= 1'b0;
            end
        end
    end
`endif

    // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        pop_c      = bus.rd_en && (count_q != '0);
        push_ok_c  = push_c && ((count_q != CW'(DEPTH)) || pop_c);
        drop_c     = push_c && !push_ok_c;
        count_nxt  = count_q + CW'(push_ok_c) - CW'(pop_c);
        rd_ptr_nxt = rd_ptr_q + AW'(pop_c);
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push_ok_c && (wr_ptr_q == rd_ptr_nxt)) begin
            head_nxt = evt_c;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr_q] <= evt_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok_c);
            rd_ptr_q <= rd_ptr_nxt;
            count_q  <= count_nxt;
            head_q   <= head_nxt;
            valid_q  <= (count_nxt != '0);
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.evt_valid  = valid_q;
    assign bus.evt_data   = head_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Randomised and directed bench for kbd_scan_ctrl against a queue-based event model.
module tb_kbd_scan_ctrl;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned T     = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    kbd_scan_ctrl_if #(.AW(AW)) bus ();

    kbd_scan_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: prefix flags, age of the pending prefix, event queue
    logic [9:0] q[$];
    logic       m_pend = 1'b0, m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
    logic       m_fv = 1'b0;
    logic [8:0] m_fk = '0;
    int         cyc = 0, m_t0 = 0;

    always @(posedge clk or negedge reset) begin
        logic       pop, push, drop, keep;
        logic [9:0] ev;
        if (!reset) begin
            q.delete();
            m_pend = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_fv = 1'b0;
        end else begin
            cyc++;
            pop  = bus.rd_en && (q.size() > 0);
            push = 1'b0; drop = 1'b0; ev = '0;
            if (bus.kbd_ready) begin
                if (bus.kbd_byte == 8'hE0) begin
                    m_ext = 1'b1; m_brk = 1'b0; m_pend = 1'b1;
                end else if (bus.kbd_byte == 8'hF0) begin
                    m_brk = 1'b1; m_pend = 1'b1;
                end else begin
                    ev   = {m_ext, m_brk, bus.kbd_byte};
                    keep = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
                    if (!m_brk) begin
                        if (m_fv && m_fk == {m_ext, bus.kbd_byte}) keep = 1'b0;
                        else begin m_fv = 1'b1; m_fk = {m_ext, bus.kbd_byte}; end
                    end else if (m_fv && m_fk == {m_ext, bus.kbd_byte}) begin
                        m_fv = 1'b0;
                    end
`endif
                    if (keep) begin
                        if (q.size() < DEPTH || pop) push = 1'b1;
                        else drop = 1'b1;
                    end
                    m_ext = 1'b0; m_brk = 1'b0; m_pend = 1'b0;
                end
                m_t0 = cyc;
            end else if (m_pend && (cyc - m_t0 >= int'(T))) begin
                m_pend = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(ev);
            if (drop) m_ovf = 1'b1;
            else if (bus.clr_ovf) m_ovf = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("evt_valid",  16'(bus.evt_valid),  16'(q.size() > 0));
            chk("evt_data",   16'(bus.evt_data),   (q.size() > 0) ? 16'(q[0]) : 16'h0);
            chk("fifo_count", 16'(bus.fifo_count), 16'(q.size()));
            chk("overflow",   16'(bus.overflow),   16'(m_ovf));
            chk("busy",       16'(bus.busy),       16'(m_pend));
        end
    end

    task automatic tick(input logic rdy, input logic [7:0] b, input logic rd, input logic clr);
        bus.kbd_ready = rdy; bus.kbd_byte = b; bus.rd_en = rd; bus.clr_ovf = clr;
        @(posedge clk); #1;
        bus.kbd_ready = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    endtask

    task automatic key(input logic [7:0] b);
        tick(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) pop1();
    endtask

    initial begin
        logic [7:0] b;
        bus.kbd_byte = '0; bus.kbd_ready = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 16'(bus.fifo_count), 16'h0);
        chk("rst_data",  16'(bus.evt_data),   16'h0);
        chk("rst_busy",  16'(bus.busy),       16'h0);
        reset = 1'b1;

        // make then break of 1C
        key(8'h1C); key(8'hF0); key(8'h1C);
        chk("t1_count", 16'(bus.fifo_count), 16'h2);
        chk("t1_head0", 16'(bus.evt_data),   16'h01C);
        pop1();
        chk("t1_head1", 16'(bus.evt_data),   16'h11C);
        pop1();

        // extended make and break
        key(8'hE0);
        chk("t2_busy_pref", 16'(bus.busy), 16'h1);
        key(8'h75);
        chk("t2_busy_done", 16'(bus.busy), 16'h0);
        chk("t2_make", 16'(bus.evt_data), 16'h275);
        key(8'hE0); key(8'hF0); key(8'h75);
        pop1();
        chk("t2_break", 16'(bus.evt_data), 16'h375);
        pop1();

        // prefix abandoned after timeout
        key(8'hE0);
        repeat (T + 3) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_busy", 16'(bus.busy), 16'h0);
        key(8'h1C);
        chk("t3_evt", 16'(bus.evt_data), 16'h01C);
        pop1();

        // overflow, push+pop while full, clear
        for (int i = 0; i <= int'(DEPTH); i++) key(8'h10 + 8'(i));
        chk("t4_count", 16'(bus.fifo_count), 16'(DEPTH));
        chk("t4_ovf",   16'(bus.overflow),   16'h1);
        chk("t4_head",  16'(bus.evt_data),   16'h010);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_clr", 16'(bus.overflow), 16'h0);
        tick(1'b1, 8'h30, 1'b1, 1'b0);
        chk("t4_pp_count", 16'(bus.fifo_count), 16'(DEPTH));
        chk("t4_pp_ovf",   16'(bus.overflow),   16'h0);
        chk("t4_pp_head",  16'(bus.evt_data),   16'h011);
        drain();

        // over-popping
        key(8'h21); key(8'h22);
        pop1(); pop1(); pop1();
        chk("t5_valid", 16'(bus.evt_valid),  16'h0);
        chk("t5_data",  16'(bus.evt_data),   16'h0);
        chk("t5_count", 16'(bus.fifo_count), 16'h0);

        // auto-repeat
        key(8'h1C); key(8'h1C); key(8'h1C); key(8'hF0); key(8'h1C); key(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
        chk("t6_count", 16'(bus.fifo_count), 16'h3);
`else
        chk("t6_count", 16'(bus.fifo_count), 16'h5);
`endif
        chk("t6_head", 16'(bus.evt_data), 16'h01C);

        // reset in the middle of E0 F0
        key(8'hE0); key(8'hF0);
        #3 reset = 1'b0;
        #1;
        chk("rst_mid_busy",  16'(bus.busy),       16'h0);
        chk("rst_mid_count", 16'(bus.fifo_count), 16'h0);
        @(posedge clk); #1 reset = 1'b1;
        key(8'h1C);
        chk("rst_mid_evt", 16'(bus.evt_data), 16'h01C);
        drain();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                repeat (T + 5) tick(1'b0, 8'h00, 1'b0, 1'b0);
            end else begin
                case ($urandom_range(0, 5))
                    0:       b = 8'hE0;
                    1:       b = 8'hF0;
                    2:       b = 8'h1C;
                    3:       b = 8'h75;
                    default: b = 8'($urandom);
                endcase
                tick(1'($urandom_range(0, 1)), b, ($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 19) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
